dac_spi_tx: RTL and testbench

Serial transmitter that takes one parallel filtered audio sample from the equalizer output path and shifts it out as a 16-bit SPI-style frame to a 12-bit DAC (DAC121S101-class: SYNC_n framing, data sampled on the SCLK falling edge). It is the output-side counterpart of the sample capture registers. It accepts a sample on a single-cycle start request, generates SCLK/SYNC_n/DOUT, and reports busy/done back to the sample-rate controller.

---
 rtl/dac_spi_tx.sv | 108 ++++++++++
 tb/tb_dac_spi_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// Serial transmitter for a 12-bit SPI DAC: sends one 16-bit frame per accepted start,
// driving SCLK/SYNC_n/DOUT and reporting busy/done to the sample-rate controller.
module dac_spi_tx #(
  parameter int         bits    = 12,
  parameter int         CLK_DIV = 4,
  parameter logic [1:0] MODE    = 2'b00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [bits-1:0] data,
  output logic            sclk,
  output logic            sync_n,
  output logic            dout,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int cnt_w = $clog2(2 * CLK_DIV) + 1;
  localparam logic [cnt_w-1:0] half_last = cnt_w'(CLK_DIV - 1);
  localparam logic [cnt_w-1:0] gap_pre   = cnt_w'(2 * CLK_DIV - 2);
  localparam logic [cnt_w-1:0] gap_last  = cnt_w'(2 * CLK_DIV - 1);

  state_t           state;
  logic [cnt_w-1:0] divcnt;
  logic [3:0]       bitcnt;
  logic [15:0]      shreg;
  logic [15:0]      frame_word;

  // Header: two zero bits, then the DAC mode bits, then the zero-padded sample code.
  assign frame_word = (16'(MODE) << 12) | 16'(data);

  // dout is the shift register MSB; clearing the register on frame exit returns it to 0.
  assign dout = shreg[15];

  // NOTE: every register here, the shift register included, is cleared by the async reset
  // and updated with non-blocking assignments so all state advances together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      divcnt <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      sclk   <= 1'b1;
      sync_n <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg  <= frame_word;
            sync_n <= 1'b0;
            busy   <= 1'b1;
            divcnt <= '0;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          if (divcnt == half_last) begin
            divcnt <= '0;
            if (sclk) begin
              // Falling edge: the DAC samples here, so dout must not move.
              sclk <= 1'b0;
            end else if (bitcnt == 4'd15) begin
              sclk   <= 1'b1;
              sync_n <= 1'b1;
              shreg  <= '0;
              state  <= GAP;
            end else begin
              sclk   <= 1'b1;
              shreg  <= {shreg[14:0], 1'b0};
              bitcnt <= bitcnt + 4'd1;
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end

        GAP: begin
          if (divcnt == gap_last) begin
            divcnt <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            divcnt <= divcnt + 1'b1;
            // Registered done must be set one cycle early to land in the last GAP cycle.
            if (divcnt == gap_pre) done <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: two instances (CLK_DIV=4/MODE=00 and CLK_DIV=1/MODE=01)
// checked every cycle against a frame-timing model, plus hand-computed frame and timing literals.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start;
  logic [11:0] data_a, data_b;
  logic [1:0]  sclk_w, sync_w, dout_w, busy_w, done_w;

  always #5 clk = ~clk;

  dac_spi_tx #(.bits(12), .CLK_DIV(4), .MODE(2'b00)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .data(data_a),
    .sclk(sclk_w[0]), .sync_n(sync_w[0]), .dout(dout_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  dac_spi_tx #(.bits(12), .CLK_DIV(1), .MODE(2'b01)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .data(data_b),
    .sclk(sclk_w[1]), .sync_n(sync_w[1]), .dout(dout_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cdiv[2]    = '{4, 1};
  logic [1:0] mode_m[2]  = '{2'b00, 2'b01};
  int         cyc        = 0;
  int         acc[2]     = '{-1, -1};
  logic [15:0] word_m[2] = '{16'h0, 16'h0};

  function automatic logic [15:0] frame_of(input logic [1:0] m, input logic [11:0] d);
    return 16'(m) * 16'h1000 + 16'(d);
  endfunction

  // Outputs {sclk, sync_n, dout, busy, done} for cycle k after the start cycle.
  function automatic logic [4:0] expect_out(input int k, input int c, input logic [15:0] w);
    int h;
    if (k >= 1 && k <= 32 * c) begin
      h = (k - 1) / c;
      return {((h % 2) == 0), 1'b0, w[15 - h / 2], 1'b1, 1'b0};
    end else if (k > 32 * c && k <= 34 * c) begin
      return {1'b1, 1'b1, 1'b0, 1'b1, (k == 34 * c)};
    end
    return 5'b11000;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) acc[i] <= -1;
      else if (start[i] && (acc[i] < 0 || cyc - acc[i] > 34 * cdiv[i])) begin
        acc[i]    <= cyc;
        word_m[i] <= frame_of(mode_m[i], (i == 0) ? data_a : data_b);
      end
    end
    cyc <= cyc + 1;
  end

  // ---------------- compare + observation ----------------
  int sync_low_cnt[2] = '{0, 0};
  int busy_cnt[2]     = '{0, 0};
  int done_cnt[2]     = '{0, 0};
  int last_done[2]    = '{0, 0};
  int fall_cyc[2]     = '{0, 0};
  int rise_cyc[2]     = '{0, 0};
  int hi_len[2]       = '{0, 0};
  int toggles[2]      = '{0, 0};
  int nbit[2]         = '{0, 0};
  int nwords[2]       = '{0, 0};
  logic [15:0] shw[2]       = '{16'h0, 16'h0};
  logic [15:0] word_last[2] = '{16'h0, 16'h0};
  logic [15:0] word_prev[2] = '{16'h0, 16'h0};
  logic prev_sync[2] = '{1'b1, 1'b1};
  logic prev_sclk[2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0] e;
      int k;
      k = (acc[i] < 0) ? -1 : cyc - acc[i];
      e = reset ? 5'b11000 : expect_out(k, cdiv[i], word_m[i]);
      check($sformatf("dut%0d {sclk,sync_n,dout,busy,done} cycle %0d", i, cyc),
            {27'd0, sclk_w[i], sync_w[i], dout_w[i], busy_w[i], done_w[i]}, {27'd0, e});

      if (!sync_w[i]) sync_low_cnt[i] <= sync_low_cnt[i] + 1;
      if (busy_w[i])  busy_cnt[i]     <= busy_cnt[i] + 1;
      if (done_w[i]) begin
        done_cnt[i]  <= done_cnt[i] + 1;
        last_done[i] <= cyc;
      end
      if (sclk_w[i] != prev_sclk[i]) toggles[i] <= toggles[i] + 1;
      if (prev_sync[i] && !sync_w[i]) begin
        fall_cyc[i] <= cyc;
        hi_len[i]   <= cyc - rise_cyc[i];
        nbit[i]     <= 0;
      end
      if (!prev_sync[i] && sync_w[i]) begin
        rise_cyc[i] <= cyc;
        if (nbit[i] == 16) begin
          word_prev[i] <= word_last[i];
          word_last[i] <= shw[i];
          nwords[i]    <= nwords[i] + 1;
        end
      end
      // DAC-side sampling at each SCLK falling edge inside a frame.
      if (prev_sclk[i] && !sclk_w[i] && !sync_w[i]) begin
        shw[i]  <= {shw[i][14:0], dout_w[i]};
        nbit[i] <= nbit[i] + 1;
      end
      prev_sync[i] <= sync_w[i];
      prev_sclk[i] <= sclk_w[i];
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s, d0, sl0, b0, nw0, t0;
    reset  = 1'b1;
    start  = 2'b00;
    data_a = 12'h000;
    data_b = 12'h000;
    repeat (3) step();
    reset = 1'b0;

    // Idle for 200 cycles with start low.
    sl0 = sync_low_cnt[0] + sync_low_cnt[1];
    b0  = busy_cnt[0] + busy_cnt[1];
    d0  = done_cnt[0] + done_cnt[1];
    t0  = toggles[0] + toggles[1];
    repeat (200) step();
    check("idle_sync_low", sync_low_cnt[0] + sync_low_cnt[1] - sl0, 0);
    check("idle_busy", busy_cnt[0] + busy_cnt[1] - b0, 0);
    check("idle_done", done_cnt[0] + done_cnt[1] - d0, 0);
    check("idle_sclk_toggles", toggles[0] + toggles[1] - t0, 0);

    // Single frame, data 0xA5C.
    data_a = 12'hA5C; start[0] = 1'b1; s = cyc;
    sl0 = sync_low_cnt[0]; b0 = busy_cnt[0]; d0 = done_cnt[0]; nw0 = nwords[0];
    step(); start[0] = 1'b0;
    repeat (140) step();
    check("t1_word", word_last[0], 16'h0A5C);
    check("t1_nwords", nwords[0] - nw0, 1);
    check("t1_sync_low", sync_low_cnt[0] - sl0, 128);
    check("t1_busy", busy_cnt[0] - b0, 136);
    check("t1_done_cnt", done_cnt[0] - d0, 1);
    check("t1_done_cycle", last_done[0] - s, 136);
    check("t1_sync_fall", fall_cyc[0] - s, 1);
    check("t1_sync_rise", rise_cyc[0] - s, 129);

    // Start held high: 0x000 then 0xFFF back to back.
    data_a = 12'h000; start[0] = 1'b1; s = cyc;
    d0 = done_cnt[0]; nw0 = nwords[0];
    step(); data_a = 12'hFFF;
    repeat (137) step(); start[0] = 1'b0;
    repeat (150) step();
    check("t2_first_word", word_prev[0], 16'h0000);
    check("t2_second_word", word_last[0], 16'h0FFF);
    check("t2_nwords", nwords[0] - nw0, 2);
    check("t2_second_fall", fall_cyc[0] - s, 138);
    check("t2_sync_high_gap", hi_len[0], 9);
    check("t2_done_cnt", done_cnt[0] - d0, 2);
    check("t2_last_done", last_done[0] - s, 273);

    // Starts at cycles 5, 100, 136 ignored; data changes not reflected.
    data_a = 12'h123; start[0] = 1'b1; s = cyc;
    d0 = done_cnt[0]; nw0 = nwords[0];
    step(); start[0] = 1'b0; data_a = 12'hFFF;
    repeat (4) step();  start[0] = 1'b1; data_a = 12'hABC;
    step(); start[0] = 1'b0;
    repeat (94) step(); start[0] = 1'b1;
    step(); start[0] = 1'b0;
    repeat (35) step(); start[0] = 1'b1;
    step(); start[0] = 1'b0;
    repeat (20) step();
    check("t3_word", word_last[0], 16'h0123);
    check("t3_nwords", nwords[0] - nw0, 1);
    check("t3_done_cnt", done_cnt[0] - d0, 1);
    check("t3_done_cycle", last_done[0] - s, 136);

    // Reset in cycle 50 mid-frame.
    data_a = 12'h5A3; start[0] = 1'b1; s = cyc;
    step(); start[0] = 1'b0;
    repeat (49) step();
    d0 = done_cnt[0]; nw0 = nwords[0];
    #1 reset = 1'b1;
    #1;
    check("t4_reset_sclk", sclk_w[0], 1);
    check("t4_reset_sync_n", sync_w[0], 1);
    check("t4_reset_dout", dout_w[0], 0);
    check("t4_reset_busy", busy_w[0], 0);
    step(); reset = 1'b0;
    repeat (100) step();
    check("t4_no_done", done_cnt[0] - d0, 0);
    check("t4_no_word", nwords[0] - nw0, 0);
    data_a = 12'h3C7; start[0] = 1'b1; s = cyc;
    step(); start[0] = 1'b0;
    repeat (140) step();
    check("t4_after_word", word_last[0], 16'h03C7);
    check("t4_after_done_cycle", last_done[0] - s, 136);
    check("t4_after_done_cnt", done_cnt[0] - d0, 1);

    // CLK_DIV=1, MODE=01, data 0x001.
    data_b = 12'h001; start[1] = 1'b1; s = cyc;
    sl0 = sync_low_cnt[1]; b0 = busy_cnt[1]; d0 = done_cnt[1]; t0 = toggles[1];
    step(); start[1] = 1'b0;
    repeat (40) step();
    check("t5_word", word_last[1], 16'h1001);
    check("t5_sync_low", sync_low_cnt[1] - sl0, 32);
    check("t5_busy", busy_cnt[1] - b0, 34);
    check("t5_done_cnt", done_cnt[1] - d0, 1);
    check("t5_done_cycle", last_done[1] - s, 34);
    check("t5_sclk_toggles", toggles[1] - t0, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
